// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter; optional ack/timeout checking under PS2_TX_ACK_CHECK_EN
module ps2_host_tx #(
    parameter int RTS_CYCLES     = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       wr_ps2,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_drv_low,
    output logic       ps2d_drv_low,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RTS   = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    localparam int              RTS_W    = $clog2(RTS_CYCLES + 1);
    localparam logic [RTS_W-1:0] RTS_LOAD = RTS_W'(RTS_CYCLES - 1);

    logic [2:0]       state_reg, state_next;
    logic [8:0]       b_reg, b_next;
    logic [3:0]       n_reg, n_next;
    logic [RTS_W-1:0] rts_reg, rts_next;

    logic [7:0] filt_c_reg;
    logic [7:0] filt_c_next;
    logic       f_c_reg, f_c_next;
    logic       fall_edge;

    // The device clock is debounced: it only changes after 8 identical samples.
    assign filt_c_next = {ps2c_in, filt_c_reg[7:1]};
    assign f_c_next    = (filt_c_next == 8'hFF) ? 1'b1 :
                         (filt_c_next == 8'h00) ? 1'b0 : f_c_reg;
    assign fall_edge   = f_c_reg & ~f_c_next;

    // Clock filter, FSM state and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_c_reg <= 8'h00;
            f_c_reg    <= 1'b0;
            state_reg  <= ST_IDLE;
            b_reg      <= 9'd0;
            n_reg      <= 4'd0;
            rts_reg    <= '0;
        end else begin
            filt_c_reg <= filt_c_next;
            f_c_reg    <= f_c_next;
            state_reg  <= state_next;
            b_reg      <= b_next;
            n_reg      <= n_next;
            rts_reg    <= rts_next;
        end
    end

`ifdef PS2_TX_ACK_CHECK_EN
    localparam int             TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

    logic [7:0]      filt_d_reg;
    logic [7:0]      filt_d_next;
    logic            f_d_reg, f_d_next;
    logic [TO_W-1:0] to_reg, to_next;
    logic            in_frame;
    logic            timeout_hit;

    // The ack is judged on the same debounced view as the clock.
    assign filt_d_next = {ps2d_in, filt_d_reg[7:1]};
    assign f_d_next    = (filt_d_next == 8'hFF) ? 1'b1 :
                         (filt_d_next == 8'h00) ? 1'b0 : f_d_reg;

    assign in_frame    = (state_reg == ST_START) || (state_reg == ST_DATA) ||
                         (state_reg == ST_STOP);
    // A real edge in the same cycle always wins over an expiring watchdog.
    assign timeout_hit = in_frame && !fall_edge && (to_reg == '0);

    // Data line filter and device-clock watchdog registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_d_reg <= 8'h00;
            f_d_reg    <= 1'b0;
            to_reg     <= '0;
        end else begin
            filt_d_reg <= filt_d_next;
            f_d_reg    <= f_d_next;
            to_reg     <= to_next;
        end
    end

    // Watchdog reloads when the device is first expected to clock and on every edge
    always_comb begin
        to_next = to_reg;
        if (state_reg == ST_RTS && rts_reg == '0) begin
            to_next = TO_LOAD;
        end else if (in_frame) begin
            if (fall_edge) begin
                to_next = TO_LOAD;
            end else if (to_reg != '0) begin
                to_next = to_reg - TO_W'(1);
            end
        end
    end
`else
    logic [32:0] unused_cfg;
    assign unused_cfg = {ps2d_in, 32'(TIMEOUT_CYCLES)};
`endif

    // Frame sequencing: request-to-send, start, 8 data + parity, stop, ack
    always_comb begin
        state_next   = state_reg;
        b_next       = b_reg;
        n_next       = n_reg;
        rts_next     = rts_reg;
        ps2c_drv_low = 1'b0;
        ps2d_drv_low = 1'b0;
        tx_idle      = 1'b0;
        tx_done_tick = 1'b0;
        ack_err      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                tx_idle = 1'b1;
                if (wr_ps2) begin
                    b_next     = {~^din, din};
                    rts_next   = RTS_LOAD;
                    state_next = ST_RTS;
                end
            end
            ST_RTS: begin
                ps2c_drv_low = 1'b1;
                if (rts_reg == '0) begin
                    state_next = ST_START;
                end else begin
                    rts_next = rts_reg - RTS_W'(1);
                end
            end
            ST_START: begin
                ps2d_drv_low = 1'b1;
                if (fall_edge) begin
                    n_next     = 4'd8;
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                ps2d_drv_low = ~b_reg[0];
                if (fall_edge) begin
                    b_next = {1'b0, b_reg[8:1]};
                    if (n_reg == 4'd0) begin
                        state_next = ST_STOP;
                    end else begin
                        n_next = n_reg - 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (fall_edge) begin
                    state_next   = ST_IDLE;
                    tx_done_tick = 1'b1;
`ifdef PS2_TX_ACK_CHECK_EN
                    ack_err      = f_d_reg;
`endif
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

`ifdef PS2_TX_ACK_CHECK_EN
        if (timeout_hit) begin
            ps2c_drv_low = 1'b0;
            ps2d_drv_low = 1'b0;
            state_next   = ST_IDLE;
            tx_done_tick = 1'b1;
            ack_err      = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with a simple PS/2 device model
module tb_ps2_host_tx;

    localparam int RTS  = 20;
    localparam int TMO  = 500;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       wr_ps2;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;
    logic       ps2c_drv_low, ps2d_drv_low, tx_idle, tx_done_tick, ack_err;

    wire ps2c_line = ~(ps2c_drv_low | dev_c_low);
    wire ps2d_line = ~(ps2d_drv_low | dev_d_low);

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;
    int rts_cnt     = 0;
    int done_cyc    = -1;
    int err_cyc     = -1;
    int last_fall_cyc = 0;

    ps2_host_tx #(
        .RTS_CYCLES    (RTS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .wr_ps2      (wr_ps2),
        .ps2c_in     (ps2c_line),
        .ps2d_in     (ps2d_line),
        .ps2c_drv_low(ps2c_drv_low),
        .ps2d_drv_low(ps2d_drv_low),
        .tx_idle     (tx_idle),
        .tx_done_tick(tx_done_tick),
        .ack_err     (ack_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done_tick) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (ack_err) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
        if (ps2c_drv_low) rts_cnt = rts_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] d);
        din    = d;
        wr_ps2 = 1'b1;
        check("pre_wr_c_low", ps2c_drv_low, 0);
        check("pre_wr_idle", tx_idle, 1);
        @(posedge clk); #1;
        wr_ps2 = 1'b0;
        check("lat_c_low", ps2c_drv_low, 1);
        check("lat_idle", tx_idle, 0);
    endtask

    // Device: waits out request-to-send, then clocks nfall falling edges,
    // sampling data on each rising edge (s[0] = start bit seen on release).
    task automatic dev_frame(input int nfall, input bit give_ack, input bit inject_wr,
                             output logic [10:0] s);
        int t;
        s = '0;
        t = 0;
        while (ps2c_drv_low !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
        check("rts_seen", ps2c_drv_low, 1);
        t = 0;
        while (ps2c_drv_low !== 1'b0 && t < 5 * RTS) begin @(posedge clk); #1; t++; end
        check("rts_release", ps2c_drv_low, 0);
        s[0] = ps2d_line;
        repeat (HALF) @(posedge clk);
        #1;
        for (int k = 1; k <= nfall; k++) begin
            dev_c_low     = 1'b1;
            last_fall_cyc = cyc;
            repeat (HALF) @(posedge clk);
            #1;
            dev_c_low = 1'b0;
            if (k <= 10) s[k] = ps2d_line;
            if (k == 10 && give_ack) dev_d_low = 1'b1;
            if (inject_wr && k == 4) begin
                din    = 8'h00;
                wr_ps2 = 1'b1;
                @(posedge clk); #1;
                wr_ps2 = 1'b0;
                repeat (HALF - 1) @(posedge clk);
                #1;
            end else begin
                repeat (HALF) @(posedge clk);
                #1;
            end
        end
        dev_d_low = 1'b0;
    endtask

    logic [7:0]  cmd_tab [3] = '{8'hF4, 8'hFF, 8'h00};
    logic [10:0] frm_tab [3] = '{11'h5E8, 11'h7FE, 11'h600};

    initial begin
        logic [10:0] s;
        int d0, e0, r0, t;

        reset  = 1'b1;
        wr_ps2 = 1'b0;
        din    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_c_low", ps2c_drv_low, 0);
        check("rst_d_low", ps2d_drv_low, 0);
        check("rst_idle", tx_idle, 1);
        check("rst_done", tx_done_tick, 0);
        check("rst_err", ack_err, 0);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // 0xED: full frame with ack
        d0 = done_cnt; e0 = err_cnt; r0 = rts_cnt;
        send_cmd(8'hED);
        dev_frame(11, 1'b1, 1'b0, s);
        check("frame_ED", s, 11'h7DA);
        check("rts_len_ED", rts_cnt - r0, RTS);
        check("done_ED", done_cnt - d0, 1);
        check("err_ED", err_cnt - e0, 0);
        check("idle_ED", tx_idle, 1);

        // parity cases
        for (int i = 0; i < 3; i++) begin
            d0 = done_cnt; e0 = err_cnt; r0 = rts_cnt;
            send_cmd(cmd_tab[i]);
            dev_frame(11, 1'b1, 1'b0, s);
            check($sformatf("frame_%02h", cmd_tab[i]), s, frm_tab[i]);
            check($sformatf("rts_len_%02h", cmd_tab[i]), rts_cnt - r0, RTS);
            check($sformatf("done_%02h", cmd_tab[i]), done_cnt - d0, 1);
            check($sformatf("err_%02h", cmd_tab[i]), err_cnt - e0, 0);
        end

        // second write during data is ignored
        d0 = done_cnt;
        send_cmd(8'hED);
        dev_frame(11, 1'b1, 1'b1, s);
        check("frame_inject", s, 11'h7DA);
        check("done_inject", done_cnt - d0, 1);
        check("idle_inject", tx_idle, 1);

        // reset after 4 data bits: d4 of 0xED is 0, so data is being pulled low
        send_cmd(8'hED);
        dev_frame(5, 1'b0, 1'b0, s);
        check("mid_d_low", ps2d_drv_low, 1);
        check("mid_idle", tx_idle, 0);
        reset = 1'b1;
        #1;
        check("mrst_c_low", ps2c_drv_low, 0);
        check("mrst_d_low", ps2d_drv_low, 0);
        check("mrst_idle", tx_idle, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        d0 = done_cnt; r0 = rts_cnt;
        send_cmd(8'hF4);
        dev_frame(11, 1'b1, 1'b0, s);
        check("frame_restart", s, 11'h5E8);
        check("rts_len_restart", rts_cnt - r0, RTS);
        check("done_restart", done_cnt - d0, 1);

`ifdef PS2_TX_ACK_CHECK_EN
        // device withholds the ack
        d0 = done_cnt; e0 = err_cnt;
        send_cmd(8'hED);
        dev_frame(11, 1'b0, 1'b0, s);
        check("frame_noack", s, 11'h7DA);
        check("done_noack", done_cnt - d0, 1);
        check("err_noack", err_cnt - e0, 1);
        check("noack_same_cycle", done_cyc, err_cyc);

        // device stops clocking after 3 bits; 0x00 keeps data pulled low
        d0 = done_cnt; e0 = err_cnt;
        send_cmd(8'h00);
        dev_frame(3, 1'b0, 1'b0, s);
        check("tmo_d_low_before", ps2d_drv_low, 1);
        t = 0;
        while (err_cnt == e0 && t < 1000) begin @(posedge clk); #1; t++; end
        check("tmo_seen", err_cnt - e0, 1);
        check("tmo_done", done_cnt - d0, 1);
        check("tmo_latency", err_cyc - last_fall_cyc, TMO + 7);
        check("tmo_same_cycle", done_cyc, err_cyc);
        check("tmo_c_low", ps2c_drv_low, 0);
        check("tmo_d_low", ps2d_drv_low, 0);
        check("tmo_idle", tx_idle, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
